i2c_burst_controller: RTL

//  Sequences one I2C burst transaction per request from the UART memory-map request/response channels.

---
 rtl/i2c_burst_controller.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_burst_controller.sv
// i2c_burst_controller
// Turns one memory-map request into a START / address / data / RESTART /
// read / STOP command sequence for the byte-level I2C engine, gathers the
// ACK status and read bytes, and returns a single response.
module i2c_burst_controller #(
    parameter int TimeoutCycles = 1562500,
    parameter int TimeoutWidth  = 21
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [6:0]  i_req_addr,
    input  logic [1:0]  i_req_wr_count,
    input  logic [1:0]  i_req_rd_count,
    input  logic [31:0] i_req_wdata,
    input  logic        i_req_rd_wrn,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_nack,
    output logic        o_rsp_timeout,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [2:0]  o_cmd_op,
    output logic [7:0]  o_cmd_wdata,
    output logic        o_cmd_ack,
    input  logic        i_done_valid,
    input  logic [7:0]  i_done_rdata,
    input  logic        i_done_nack,
    output logic        o_busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR_W,
        S_WDATA,
        S_RESTART,
        S_ADDR_R,
        S_RDATA,
        S_STOP,
        S_RESP
    } state_t;

    localparam logic [2:0] OpStart   = 3'd0;
    localparam logic [2:0] OpWrite   = 3'd1;
    localparam logic [2:0] OpRead    = 3'd2;
    localparam logic [2:0] OpStop    = 3'd3;
    localparam logic [2:0] OpRestart = 3'd4;

    localparam logic [TimeoutWidth-1:0] TmoLimit = TimeoutWidth'(TimeoutCycles);

    // Sequencer state: r_wait distinguishes the WAIT phase from the ISSUE phase
    state_t                  r_state, w_state_nxt;
    logic                    r_wait, w_wait_nxt;
    logic [1:0]              r_idx, w_idx_nxt;
    logic [TimeoutWidth-1:0] r_tmo_cnt, w_tmo_cnt_nxt;

    // Captured request fields
    logic [6:0]  r_addr, w_addr_nxt;
    logic [1:0]  r_wr_cnt, w_wr_cnt_nxt;
    logic [1:0]  r_rd_cnt, w_rd_cnt_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_rd_wrn, w_rd_wrn_nxt;

    // Registered interface outputs
    logic        r_req_ready, w_req_ready_nxt;
    logic        r_cmd_valid, w_cmd_valid_nxt;
    logic [2:0]  r_cmd_op, w_cmd_op_nxt;
    logic [7:0]  r_cmd_wdata, w_cmd_wdata_nxt;
    logic        r_cmd_ack, w_cmd_ack_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic        r_rsp_nack, w_rsp_nack_nxt;
    logic        r_rsp_timeout, w_rsp_timeout_nxt;

    logic w_issue;
    logic w_xfer;
    logic w_accept;

    assign w_xfer   = r_cmd_valid & i_cmd_ready;
    // r_req_ready is only ever high while idle
    assign w_accept = i_req_valid & r_req_ready;

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_nack    = r_rsp_nack;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_op      = r_cmd_op;
    assign o_cmd_wdata   = r_cmd_wdata;
    assign o_cmd_ack     = r_cmd_ack;
    assign o_busy        = (r_state != S_IDLE);

    // Next-state, command and response computation
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_nxt        = r_wait;
        w_idx_nxt         = r_idx;
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_addr_nxt        = r_addr;
        w_wr_cnt_nxt      = r_wr_cnt;
        w_rd_cnt_nxt      = r_rd_cnt;
        w_wdata_nxt       = r_wdata;
        w_rd_wrn_nxt      = r_rd_wrn;
        w_req_ready_nxt   = r_req_ready;
        w_cmd_valid_nxt   = r_cmd_valid;
        w_cmd_op_nxt      = r_cmd_op;
        w_cmd_wdata_nxt   = r_cmd_wdata;
        w_cmd_ack_nxt     = r_cmd_ack;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_nack_nxt    = r_rsp_nack;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_issue           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_addr_nxt        = i_req_addr;
                    w_wr_cnt_nxt      = i_req_wr_count;
                    w_rd_cnt_nxt      = i_req_rd_count;
                    w_wdata_nxt       = i_req_wdata;
                    w_rd_wrn_nxt      = i_req_rd_wrn;
                    w_req_ready_nxt   = 1'b0;
                    w_rsp_rdata_nxt   = 32'h0;
                    w_rsp_nack_nxt    = 1'b0;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = S_START;
                    w_issue           = 1'b1;
                end
            end

            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt       = S_IDLE;
                    w_rsp_valid_nxt   = 1'b0;
                    w_rsp_rdata_nxt   = 32'h0;
                    w_rsp_nack_nxt    = 1'b0;
                    w_rsp_timeout_nxt = 1'b0;
                    w_req_ready_nxt   = 1'b1;
                end
            end

            default: begin
                if (!r_wait) begin
                    // ISSUE: hold the command until the engine takes it
                    if (w_xfer) begin
                        w_cmd_valid_nxt = 1'b0;
                        w_wait_nxt      = 1'b1;
                        w_tmo_cnt_nxt   = '0;
                    end
                end else if (i_done_valid) begin
                    // WAIT: completion takes priority over a coincident timeout
                    unique case (r_state)
                        S_START: begin
                            w_state_nxt = S_ADDR_W;
                            w_issue     = 1'b1;
                        end
                        S_ADDR_W: begin
                            if (i_done_nack) begin
                                w_rsp_nack_nxt = 1'b1;
                                w_state_nxt    = S_STOP;
                            end else begin
                                w_state_nxt = S_WDATA;
                                w_idx_nxt   = 2'd0;
                            end
                            w_issue = 1'b1;
                        end
                        S_WDATA: begin
                            if (i_done_nack) begin
                                w_rsp_nack_nxt = 1'b1;
                                w_state_nxt    = S_STOP;
                            end else if (r_idx == r_wr_cnt) begin
                                w_state_nxt = r_rd_wrn ? S_RESTART : S_STOP;
                            end else begin
                                w_idx_nxt = r_idx + 2'd1;
                            end
                            w_issue = 1'b1;
                        end
                        S_RESTART: begin
                            w_state_nxt = S_ADDR_R;
                            w_issue     = 1'b1;
                        end
                        S_ADDR_R: begin
                            if (i_done_nack) begin
                                w_rsp_nack_nxt = 1'b1;
                                w_state_nxt    = S_STOP;
                            end else begin
                                w_state_nxt = S_RDATA;
                                w_idx_nxt   = 2'd0;
                            end
                            w_issue = 1'b1;
                        end
                        S_RDATA: begin
                            w_rsp_rdata_nxt[{r_idx, 3'b000} +: 8] = i_done_rdata;
                            if (r_idx == r_rd_cnt) begin
                                w_state_nxt = S_STOP;
                            end else begin
                                w_idx_nxt = r_idx + 2'd1;
                            end
                            w_issue = 1'b1;
                        end
                        S_STOP: begin
                            w_state_nxt     = S_RESP;
                            w_wait_nxt      = 1'b0;
                            w_rsp_valid_nxt = 1'b1;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                            w_wait_nxt  = 1'b0;
                        end
                    endcase
                end else if (r_tmo_cnt == TmoLimit) begin
                    // Engine is stuck: report without attempting a STOP
                    w_state_nxt       = S_RESP;
                    w_wait_nxt        = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end
        endcase

        // Entering an ISSUE phase loads the command for the destination state
        if (w_issue) begin
            w_wait_nxt      = 1'b0;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_wdata_nxt = 8'h00;
            w_cmd_ack_nxt   = 1'b0;
            unique case (w_state_nxt)
                S_START:   w_cmd_op_nxt = OpStart;
                S_ADDR_W: begin
                    w_cmd_op_nxt    = OpWrite;
                    w_cmd_wdata_nxt = {r_addr, 1'b0};
                end
                S_WDATA: begin
                    w_cmd_op_nxt    = OpWrite;
                    w_cmd_wdata_nxt = r_wdata[{w_idx_nxt, 3'b000} +: 8];
                end
                S_RESTART: w_cmd_op_nxt = OpRestart;
                S_ADDR_R: begin
                    w_cmd_op_nxt    = OpWrite;
                    w_cmd_wdata_nxt = {r_addr, 1'b1};
                end
                S_RDATA: begin
                    w_cmd_op_nxt  = OpRead;
                    // Master NACKs only the final read byte
                    w_cmd_ack_nxt = (w_idx_nxt != r_rd_cnt);
                end
                S_STOP:    w_cmd_op_nxt = OpStop;
                default:   w_cmd_op_nxt = OpStop;
            endcase
        end
    end

    // State and output registers; reset aborts any transaction silently
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_wait        <= 1'b0;
            r_idx         <= 2'd0;
            r_tmo_cnt     <= '0;
            r_addr        <= 7'h0;
            r_wr_cnt      <= 2'd0;
            r_rd_cnt      <= 2'd0;
            r_wdata       <= 32'h0;
            r_rd_wrn      <= 1'b0;
            r_req_ready   <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_op      <= 3'd0;
            r_cmd_wdata   <= 8'h00;
            r_cmd_ack     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_nack    <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait        <= w_wait_nxt;
            r_idx         <= w_idx_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_addr        <= w_addr_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_rd_cnt      <= w_rd_cnt_nxt;
            r_wdata       <= w_wdata_nxt;
            r_rd_wrn      <= w_rd_wrn_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_cmd_op      <= w_cmd_op_nxt;
            r_cmd_wdata   <= w_cmd_wdata_nxt;
            r_cmd_ack     <= w_cmd_ack_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_nack    <= w_rsp_nack_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

endmodule
